shake_arbiter: RTL

SHAKE_ARBITER -- requirements
Module: shake_arbiter

---
 rtl/shake_arbiter_pkg.sv | 22 ++
 rtl/shake_rr_arb2.sv | 37 +++
 rtl/shake_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/shake_arbiter_pkg.sv
// Shared definitions for the two-requester SHAKE core arbiter.
package shake_arbiter_pkg;

  localparam int SHAKE_DW      = 1344;
  localparam int RATE128_BYTES = 168;
  localparam int RATE256_BYTES = 136;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_OWN   = 2'd2
  } arb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/shake_rr_arb2.sv
// Two-way round-robin picker; the pointer remembers the last requester granted.
module shake_rr_arb2
  import shake_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       any_o,
  output logic       win_o
);

  logic last_r;
  logic win_s;

  // On a tie the requester not granted last wins; otherwise the lone requester.
  always_comb begin
    if (req_i == 2'b11) begin
      win_s = ~last_r;
    end else begin
      win_s = req_i[1];
    end
  end

  assign any_o = |req_i;
  assign win_o = win_s;

  // Last-grant pointer; reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_r <= 1'b1;
    end else if (update_i) begin
      last_r <= win_s;
    end
  end

endmodule

// File: rtl/shake_arbiter.sv
// Arbitrates one external SHAKE core between two requesters (IDLE -> START -> OWN).
// Define SHAKE_ARBITER_CNT_EN to add per-requester absorb/squeeze handshake counters.
module shake_arbiter
  import shake_arbiter_pkg::*;
#(
  parameter int DW = SHAKE_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
`ifdef SHAKE_ARBITER_CNT_EN
  output logic [15:0]   abs_cnt0_o,
  output logic [15:0]   sqz_cnt0_o,
  output logic [15:0]   abs_cnt1_o,
  output logic [15:0]   sqz_cnt1_o,
`endif
  input  logic          req0_i,
  input  logic          sel128_0_i,
  input  logic          rel0_i,
  input  logic          req1_i,
  input  logic          sel128_1_i,
  input  logic          rel1_i,
  input  logic [DW-1:0] din0_i,
  input  logic          din_valid0_i,
  input  logic          last_din0_i,
  input  logic [7:0]    last_din_byte0_i,
  input  logic          dout_ready0_i,
  input  logic [DW-1:0] din1_i,
  input  logic          din_valid1_i,
  input  logic          last_din1_i,
  input  logic [7:0]    last_din_byte1_i,
  input  logic          dout_ready1_i,
  output logic          gnt0_o,
  output logic          din_ready0_o,
  output logic          dout_valid0_o,
  output logic          gnt1_o,
  output logic          din_ready1_o,
  output logic          dout_valid1_o,
  output logic [DW-1:0] dout_o,
  output logic          core_start_o,
  output logic          core_sel_shake128_o,
  output logic [DW-1:0] core_din_o,
  output logic          core_din_valid_o,
  output logic          core_last_din_o,
  output logic [7:0]    core_last_din_byte_o,
  output logic          core_dout_ready_o,
  input  logic          core_din_ready_i,
  input  logic [DW-1:0] core_dout_i,
  input  logic          core_dout_valid_i
);

  arb_state_e state_r;
  logic       owner_r;
  logic       sel_r;
  logic       start_r;
  logic       gnt0_r;
  logic       gnt1_r;
  logic       any_s;
  logic       win_s;
  logic       own_s;
  logic       rel_own_s;

  shake_rr_arb2 u_rr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({req1_i, req0_i}),
    .update_i ((state_r == ST_IDLE) && any_s),
    .any_o    (any_s),
    .win_o    (win_s)
  );

  assign own_s     = (state_r == ST_OWN);
  assign rel_own_s = own_s && (owner_r ? rel1_i : rel0_i);

  // Ownership FSM; start, sel and grants are registered alongside the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b0;
      sel_r   <= 1'b0;
      start_r <= 1'b0;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            state_r <= ST_START;
            owner_r <= win_s;
            sel_r   <= win_s ? sel128_1_i : sel128_0_i;
            start_r <= 1'b1;
            gnt0_r  <= ~win_s;
            gnt1_r  <= win_s;
          end
        end
        ST_START: begin
          state_r <= ST_OWN;
          start_r <= 1'b0;
        end
        ST_OWN: begin
          if (rel_own_s) begin
            state_r <= ST_IDLE;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          start_r <= 1'b0;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0_o              = gnt0_r;
  assign gnt1_o              = gnt1_r;
  assign core_start_o        = start_r;
  assign core_sel_shake128_o = sel_r;
  assign dout_o              = core_dout_i;

  // Owner's stream is wired straight through only while in OWN.
  always_comb begin
    core_din_o           = {DW{1'b0}};
    core_din_valid_o     = 1'b0;
    core_last_din_o      = 1'b0;
    core_last_din_byte_o = 8'd0;
    core_dout_ready_o    = 1'b0;
    din_ready0_o         = 1'b0;
    din_ready1_o         = 1'b0;
    dout_valid0_o        = 1'b0;
    dout_valid1_o        = 1'b0;
    if (own_s && owner_r) begin
      core_din_o           = din1_i;
      core_din_valid_o     = din_valid1_i;
      core_last_din_o      = last_din1_i;
      core_last_din_byte_o = last_din_byte1_i;
      core_dout_ready_o    = dout_ready1_i;
      din_ready1_o         = core_din_ready_i;
      dout_valid1_o        = core_dout_valid_i;
    end else if (own_s) begin
      core_din_o           = din0_i;
      core_din_valid_o     = din_valid0_i;
      core_last_din_o      = last_din0_i;
      core_last_din_byte_o = last_din_byte0_i;
      core_dout_ready_o    = dout_ready0_i;
      din_ready0_o         = core_din_ready_i;
      dout_valid0_o        = core_dout_valid_i;
    end else begin
      core_din_valid_o     = 1'b0;
    end
  end

`ifdef SHAKE_ARBITER_CNT_EN
  logic        din_hs_s;
  logic        dout_hs_s;
  logic [15:0] abs_cnt0_r;
  logic [15:0] sqz_cnt0_r;
  logic [15:0] abs_cnt1_r;
  logic [15:0] sqz_cnt1_r;

  assign din_hs_s  = core_din_valid_o && core_din_ready_i;
  assign dout_hs_s = core_dout_valid_i && core_dout_ready_o;

  // Saturating handshake counters; handshakes only exist in OWN, credited to the owner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      abs_cnt0_r <= 16'd0;
      sqz_cnt0_r <= 16'd0;
      abs_cnt1_r <= 16'd0;
      sqz_cnt1_r <= 16'd0;
    end else begin
      if (din_hs_s && !owner_r) abs_cnt0_r <= sat_inc16(abs_cnt0_r);
      if (dout_hs_s && !owner_r) sqz_cnt0_r <= sat_inc16(sqz_cnt0_r);
      if (din_hs_s && owner_r) abs_cnt1_r <= sat_inc16(abs_cnt1_r);
      if (dout_hs_s && owner_r) sqz_cnt1_r <= sat_inc16(sqz_cnt1_r);
    end
  end

  assign abs_cnt0_o = abs_cnt0_r;
  assign sqz_cnt0_o = sqz_cnt0_r;
  assign abs_cnt1_o = abs_cnt1_r;
  assign sqz_cnt1_o = sqz_cnt1_r;
`endif

endmodule
